// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive/transmit pair.
// Holds the receiver state encoding and oversampling constants.
package serial_pkg;

    localparam int OVERSAMPLE             = 16;
    localparam int MID_SAMPLE             = 8;
    localparam int DEFAULT_OVERSAMPLE_DIV = 54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/serial_baud_tick.sv
// Oversampling divider: one-clock tick every DIV clocks.
// A synchronous clear realigns the tick phase to an external event.
module serial_baud_tick
    import serial_pkg::*;
#(
    parameter int DIV = DEFAULT_OVERSAMPLE_DIV
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, wrap on terminal count, else increment.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver, LSB first, 16x oversampled.
// Presents each byte with a valid/ack handshake and error flags.
module serial_rx
    import serial_pkg::*;
#(
    parameter int OVERSAMPLE_DIV = DEFAULT_OVERSAMPLE_DIV,
    parameter int DATA_BITS      = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       serialin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [3:0] MID_T  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] LAST_T = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_I = 3'(DATA_BITS - 1);

    rx_state_e  state_q, state_d;
    logic       sync1_q, sync2_q;
    logic       line;
    logic       tick;
    logic       div_clr;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       accept;

    assign line      = sync2_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = ferr_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

    serial_baud_tick #(
        .DIV (OVERSAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (div_clr),
        .tick (tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serialin;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM: start qualification, data shift, stop check, break hold.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        div_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!line) begin
                    div_clr = 1'b1;
                    tcnt_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == MID_T) begin
                        if (line) begin
                            state_d = ST_IDLE;
                        end else begin
                            tcnt_d  = '0;
                            idx_d   = '0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == LAST_T) begin
                        shift_d[idx_q] = line;
                        if (idx_q == LAST_I) state_d = ST_STOP;
                        else                 idx_d   = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == LAST_T) begin
                        if (line) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (line) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output handshake: load on completion, flag overrun, clear on ack.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        accept     = rx_valid_q && rx_ack;
        if (done_q && (!rx_valid_q || rx_ack)) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (accept) overrun_d = 1'b0;
        end else if (done_q) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Directed testbench for serial_rx.
// Drives serial frames on negedges and samples outputs on negedges.
module tb_serial_rx;

    localparam int DIV   = 32;
    localparam int BIT   = DIV * 16;
    localparam int FRAME = BIT * 10;
    localparam int LAT   = 2 + 9 * BIT + 8 * DIV + 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       serialin = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;
    int vrise  = 0;
    int ccount = 0;
    logic vprev = 1'b0;

    serial_rx #(
        .OVERSAMPLE_DIV (DIV)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .serialin  (serialin),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ccount <= ccount + 1;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (rx_valid === 1'b1 && vprev !== 1'b1) vrise <= vrise + 1;
        vprev <= rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        serialin = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serialin = d[i];
            repeat (BIT) @(negedge clk);
        end
        serialin = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (rx_valid !== 1'b1) begin
            @(negedge clk);
            cyc++;
            if (cyc >= max) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        serialin = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rx_data !== 8'h00) begin
            bad++; $display("FAIL reset_data got=%h exp=00", rx_data);
        end
        total++;
        if ({rx_valid, frame_err, overrun, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {rx_valid, frame_err, overrun, busy});
        end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int lat;
        bit to;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_valid(FRAME, lat, to);
                total++;
                if (to || lat < LAT - DIV || lat > LAT + DIV) begin
                    bad++;
                    $display("FAIL single_latency got=%0d exp=%0d", lat, LAT);
                end
                total++;
                if (rx_data !== 8'hA5) begin
                    bad++; $display("FAIL single_data got=%h exp=a5", rx_data);
                end
                repeat (10) @(negedge clk);
                total++;
                if (rx_valid !== 1'b1) begin
                    bad++; $display("FAIL single_hold got=%b exp=1", rx_valid);
                end
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                total++;
                if (rx_valid !== 1'b0) begin
                    bad++; $display("FAIL single_ackclr got=%b exp=0", rx_valid);
                end
                total++;
                if (fe_cnt !== 0 || overrun !== 1'b0) begin
                    bad++;
                    $display("FAIL single_errs got=%0d/%b exp=0/0", fe_cnt, overrun);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        int n, t1, t2;
        bit to;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_valid(2 * FRAME, n, to);
                t1 = ccount;
                total++;
                if (to || rx_data !== 8'h00) begin
                    bad++; $display("FAIL b2b_first got=%h to=%0d exp=00", rx_data, to);
                end
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                wait_valid(2 * FRAME, n, to);
                t2 = ccount;
                total++;
                if (to || rx_data !== 8'hFF) begin
                    bad++; $display("FAIL b2b_second got=%h to=%0d exp=ff", rx_data, to);
                end
                total++;
                if (t2 - t1 < FRAME - DIV || t2 - t1 > FRAME + DIV) begin
                    bad++; $display("FAIL b2b_gap got=%0d exp=%0d", t2 - t1, FRAME);
                end
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
    endtask

    task automatic test_glitch();
        int fe0, v0, n;
        bit seen;
        fe0 = fe_cnt;
        v0 = vrise;
        seen = 1'b0;
        serialin = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        serialin = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 16 * DIV) begin
            @(negedge clk);
            n++;
        end
        repeat (BIT) @(negedge clk);
        total++;
        if (seen !== 1'b1) begin
            bad++; $display("FAIL glitch_busy_seen got=%b exp=1", seen);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL glitch_idle got=%b exp=0", busy);
        end
        total++;
        if (vrise != v0 || fe_cnt != fe0 || rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL glitch_quiet got=v%0d/fe%0d exp=v%0d/fe%0d",
                     vrise, fe_cnt, v0, fe0);
        end
    endtask

    task automatic test_break();
        int fe0, v0;
        fe0 = fe_cnt;
        v0 = vrise;
        send_frame(8'h3C, 1'b0);
        repeat (3 * BIT) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL break_busy got=%b exp=1", busy);
        end
        total++;
        if (fe_cnt - fe0 != 1) begin
            bad++; $display("FAIL break_ferr got=%0d exp=1", fe_cnt - fe0);
        end
        serialin = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL break_release got=%b exp=0", busy);
        end
        total++;
        if (vrise != v0 || rx_valid !== 1'b0) begin
            bad++; $display("FAIL break_novalid got=%0d exp=%0d", vrise, v0);
        end
    endtask

    task automatic test_overrun();
        int n;
        bit to;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (8) @(negedge clk);
        total++;
        if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
            bad++; $display("FAIL ovr_keep got=%h/%b exp=11/1", rx_data, rx_valid);
        end
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_flag got=%b exp=1", overrun);
        end
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        total++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_ackclr got=%b/%b exp=0/0", rx_valid, overrun);
        end
        send_frame(8'h11, 1'b1);
        total++;
        if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
            bad++; $display("FAIL ovr_rep1 got=%h/%b exp=11/1", rx_data, rx_valid);
        end
        fork
            send_frame(8'h22, 1'b1);
            begin
                n = 0;
                while (busy !== 1'b1 && n < BIT) begin
                    @(negedge clk);
                    n++;
                end
                to = (n >= BIT);
                n = 0;
                while (busy !== 1'b0 && n < 2 * FRAME) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 2 * FRAME) to = 1'b1;
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                total++;
                if (to || rx_data !== 8'h22 || rx_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL ovr_same_clk got=%h/%b to=%0d exp=22/1",
                             rx_data, rx_valid, to);
                end
                total++;
                if (overrun !== 1'b0) begin
                    bad++; $display("FAIL ovr_same_flag got=%b exp=0", overrun);
                end
            end
        join
        repeat (4) @(negedge clk);
        total++;
        if (rx_valid !== 1'b1 || overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_settle got=%b/%b exp=1/0", rx_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h5A;
        serialin = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            serialin = d[i];
            repeat (BIT) @(negedge clk);
        end
        serialin = d[4];
        repeat (BIT / 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if (rx_data !== 8'h00) begin
            bad++; $display("FAIL rst_mid_data got=%h exp=00", rx_data);
        end
        total++;
        if ({rx_valid, frame_err, overrun, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_flags got=%b exp=0000",
                     {rx_valid, frame_err, overrun, busy});
        end
        serialin = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        repeat (BIT) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rx_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_after got=%b/%b exp=0/0", busy, rx_valid);
        end
        send_frame(8'h5A, 1'b1);
        total++;
        if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin
            bad++; $display("FAIL rst_mid_clean got=%h/%b exp=5a/1", rx_data, rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
